// File: rtl/eq_pkg.sv
// Shared types and defaults for the equalizer band-filter sequencer.
package eq_pkg;

  localparam int SMPL_W    = 16;
  localparam int TAPS_DEF  = 1021;
  localparam int DEPTH_DEF = 1024;
  localparam int LAT_DEF   = 2;

  typedef enum logic [1:0] {
    FILL = 2'd0,
    WAIT = 2'd1,
    RUN  = 2'd2,
    CAPT = 2'd3
  } seq_state_t;

endpackage

// File: rtl/eq_band_seq_ctrl_if.sv
// Codec/filter-side signal bundle of the band sequencer.
interface eq_band_seq_ctrl_if
  import eq_pkg::*;
#(
  parameter int PTR_W = $clog2(DEPTH_DEF)
);

  logic              smpl_vld;
  logic [SMPL_W-1:0] filt_lft;
  logic [SMPL_W-1:0] filt_rght;
  logic              wr_en;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              sequencing;
  logic [SMPL_W-1:0] aud_lft;
  logic [SMPL_W-1:0] aud_rght;
  logic              out_vld;
  logic              busy;
  logic              overrun;

  modport slave (
    input  smpl_vld, filt_lft, filt_rght,
    output wr_en, wr_ptr, rd_ptr, sequencing, aud_lft, aud_rght,
           out_vld, busy, overrun
  );

  modport master (
    output smpl_vld, filt_lft, filt_rght,
    input  wr_en, wr_ptr, rd_ptr, sequencing, aud_lft, aud_rght,
           out_vld, busy, overrun
  );

endinterface

// File: rtl/eq_band_seq_ctrl_ring_ptr.sv
// Wrap-around ring-buffer pointer: load has priority over increment.
module ring_ptr #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic         inc_i,
  input  logic [W-1:0] load_val_i,
  output logic [W-1:0] ptr_o
);

  logic [W-1:0] ptr_q;
  logic [W-1:0] ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (load_i) begin
      ptr_d = load_val_i;
    end else if (inc_i) begin
      ptr_d = ptr_q + W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/eq_band_seq_ctrl.sv
// Equalizer band-filter sequencer: writes codec samples into the shared ring
// and runs one TAPS-long read pass per sample, capturing the filter results.
module eq_band_seq_ctrl
  import eq_pkg::*;
#(
  parameter int TAPS  = TAPS_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int LAT   = LAT_DEF
) (
  input logic               clk,
  input logic               rst,
  eq_band_seq_ctrl_if.slave bus
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = $clog2(TAPS + LAT);
  localparam int FILL_W = $clog2(TAPS);
  localparam int WR     = 0;
  localparam int RD     = 1;

  localparam logic [CNT_W-1:0]  CNT_LAST    = CNT_W'(TAPS - 1 + LAT);
  localparam logic [CNT_W-1:0]  CNT_RD_LAST = CNT_W'(TAPS - 1);
  localparam logic [FILL_W-1:0] FILL_LAST   = FILL_W'(TAPS - 1);
  localparam logic [PTR_W-1:0]  WIN_SPAN    = PTR_W'(TAPS - 1);

  seq_state_t        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic              overrun_q;
  logic [SMPL_W-1:0] aud_lft_q, aud_rght_q;

  logic              cap_en;
  logic              rd_load;
  logic              rd_inc;

  logic [1:0]        ptr_load;
  logic [1:0]        ptr_inc;
  logic [PTR_W-1:0]  ptr_val [2];
  logic [PTR_W-1:0]  ptr_q   [2];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fill_d  = fill_q;
    cap_en  = 1'b0;
    rd_load = 1'b0;
    rd_inc  = 1'b0;
    case (state_q)
      FILL: begin
        if (bus.smpl_vld) begin
          if (fill_q == FILL_LAST) begin
            state_d = RUN;
            fill_d  = '0;
            cnt_d   = '0;
            rd_load = 1'b1;
          end else begin
            fill_d = fill_q + FILL_W'(1);
          end
        end
      end
      WAIT: begin
        if (bus.smpl_vld) begin
          state_d = RUN;
          cnt_d   = '0;
          rd_load = 1'b1;
        end
      end
      RUN: begin
        if (cnt_q == CNT_LAST) begin
          state_d = CAPT;
          cap_en  = 1'b1;
        end else begin
          cnt_d  = cnt_q + CNT_W'(1);
          // Read pointer parks on the newest sample while the filter pipeline drains.
          rd_inc = (cnt_q < CNT_RD_LAST);
        end
      end
      CAPT: begin
        state_d = WAIT;
      end
      default: begin
        state_d = FILL;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FILL;
      cnt_q   <= '0;
      fill_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fill_q  <= fill_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overrun_q <= 1'b0;
    end else if (bus.smpl_vld && (state_q == RUN || state_q == CAPT)) begin
      overrun_q <= 1'b1;
    end
  end

  // Results are latched on the last pass cycle so aud_* are valid while out_vld is high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      aud_lft_q  <= '0;
      aud_rght_q <= '0;
    end else if (cap_en) begin
      aud_lft_q  <= bus.filt_lft;
      aud_rght_q <= bus.filt_rght;
    end
  end

  // The window starts at the oldest of the TAPS samples ending at the one being written now.
  assign ptr_load[WR] = 1'b0;
  assign ptr_inc[WR]  = bus.smpl_vld;
  assign ptr_val[WR]  = '0;
  assign ptr_load[RD] = rd_load;
  assign ptr_inc[RD]  = rd_inc;
  assign ptr_val[RD]  = ptr_q[WR] - WIN_SPAN;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_ptr
      ring_ptr #(
        .W (PTR_W)
      ) u_ring_ptr (
        .clk        (clk),
        .rst        (rst),
        .load_i     (ptr_load[gi]),
        .inc_i      (ptr_inc[gi]),
        .load_val_i (ptr_val[gi]),
        .ptr_o      (ptr_q[gi])
      );
    end
  endgenerate

  assign bus.wr_en      = bus.smpl_vld;
  assign bus.wr_ptr     = ptr_q[WR];
  assign bus.rd_ptr     = ptr_q[RD];
  assign bus.sequencing = (state_q == RUN);
  assign bus.busy       = (state_q == RUN);
  assign bus.out_vld    = (state_q == CAPT);
  assign bus.overrun    = overrun_q;
  assign bus.aud_lft    = aud_lft_q;
  assign bus.aud_rght   = aud_rght_q;

endmodule

// File: tb/tb_eq_band_seq_ctrl.sv
// Directed bench for eq_band_seq_ctrl: fill, table of passes, wrap, overrun, mid-pass reset.
module tb_eq_band_seq_ctrl;
  import eq_pkg::*;

  localparam int TAPS  = 1021;
  localparam int DEPTH = 1024;
  localparam int LAT   = 2;
  localparam int PTR_W = 10;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  eq_band_seq_ctrl_if #(.PTR_W(PTR_W)) bus ();

  eq_band_seq_ctrl #(
    .TAPS  (TAPS),
    .DEPTH (DEPTH),
    .LAT   (LAT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [15:0] fl;
    logic [15:0] fr;
    logic [9:0]  exp_start;
    int          ovr_at;
    int          ovr_cnt;
    logic [9:0]  exp_wr_end;
    logic        exp_ovr;
  } pass_t;

  pass_t passes [4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  task automatic step(input logic s);
    bus.smpl_vld = s;
    @(posedge clk);
    #1;
    bus.smpl_vld = 1'b0;
  endtask

  // 1020 samples must not start a pass; the 1021st must.
  task automatic fill_window();
    logic seq_seen;
    seq_seen = 1'b0;
    for (int i = 0; i < TAPS - 1; i++) begin
      step(1'b1);
      seq_seen = seq_seen | bus.sequencing;
    end
    check("fill_seq_low", 32'(seq_seen), 32'd0);
    check("fill_wr_ptr", 32'(bus.wr_ptr), 32'd1020);
    bus.smpl_vld = 1'b1;
    #1;
    check("fill_wr_en", 32'(bus.wr_en), 32'd1);
    step(1'b1);
    check("fill_seq_rise", 32'(bus.sequencing), 32'd1);
  endtask

  // Called with the first RUN cycle sampled; ends with the WAIT cycle after CAPT sampled.
  task automatic run_pass(input int idx);
    pass_t       p;
    logic        bad;
    logic [9:0]  exp_rd;
    logic [11:0] bad_act, bad_exp;
    p   = passes[idx];
    bad = 1'b0;
    bad_act = '0;
    bad_exp = '0;
    check($sformatf("pass%0d_busy", idx), 32'(bus.busy), 32'd1);
    check($sformatf("pass%0d_start", idx), 32'(bus.rd_ptr), 32'(p.exp_start));
    for (int k = 0; k < TAPS + LAT; k++) begin
      exp_rd = p.exp_start + 10'((k < TAPS - 1) ? k : TAPS - 1);
      if (!bad) begin
        bad_act = {bus.sequencing, bus.out_vld, bus.rd_ptr};
        bad_exp = {1'b1, 1'b0, exp_rd};
        bad     = (bad_act !== bad_exp);
      end
      step((k >= p.ovr_at) && (k < p.ovr_at + p.ovr_cnt));
    end
    check($sformatf("pass%0d_walk", idx), 32'(bad_act), 32'(bad_exp));
    check($sformatf("pass%0d_capt_vld", idx), 32'(bus.out_vld), 32'd1);
    check($sformatf("pass%0d_capt_seq", idx), 32'(bus.sequencing), 32'd0);
    check($sformatf("pass%0d_aud_lft", idx), 32'(bus.aud_lft), 32'(p.fl));
    check($sformatf("pass%0d_aud_rght", idx), 32'(bus.aud_rght), 32'(p.fr));
    check($sformatf("pass%0d_wr_ptr", idx), 32'(bus.wr_ptr), 32'(p.exp_wr_end));
    check($sformatf("pass%0d_overrun", idx), 32'(bus.overrun), 32'(p.exp_ovr));
    step(1'b0);
    check($sformatf("pass%0d_wait_vld", idx), 32'(bus.out_vld), 32'd0);
    check($sformatf("pass%0d_wait_seq", idx), 32'(bus.sequencing), 32'd0);
    check($sformatf("pass%0d_aud_hold", idx), 32'(bus.aud_lft), 32'(p.fl));
  endtask

  initial begin
    // fl, fr, start, ovr_at, ovr_cnt, wr_ptr at capture, overrun at capture
    passes[0] = '{16'h1234, 16'hABCD, 10'd0,    0,    0, 10'd1021, 1'b0};
    passes[1] = '{16'h0001, 16'hFFFF, 10'd1,  500,    1, 10'd1023, 1'b1};
    passes[2] = '{16'h8000, 16'h7FFF, 10'd3,    1, 1000, 10'd1000, 1'b1};
    passes[3] = '{16'h5A5A, 16'hA5A5, 10'd1004, 0,    0, 10'd1001, 1'b1};

    rst           = 1'b1;
    bus.smpl_vld  = 1'b0;
    bus.filt_lft  = 16'h0;
    bus.filt_rght = 16'h0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_seq", 32'(bus.sequencing), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_out_vld", 32'(bus.out_vld), 32'd0);
    check("rst_overrun", 32'(bus.overrun), 32'd0);
    check("rst_wr_en", 32'(bus.wr_en), 32'd0);
    check("rst_wr_ptr", 32'(bus.wr_ptr), 32'd0);
    check("rst_rd_ptr", 32'(bus.rd_ptr), 32'd0);
    check("rst_aud_lft", 32'(bus.aud_lft), 32'd0);
    check("rst_aud_rght", 32'(bus.aud_rght), 32'd0);
    rst = 1'b0;

    // Later passes are triggered in the WAIT cycle directly after CAPT.
    for (int i = 0; i < 4; i++) begin
      bus.filt_lft  = passes[i].fl;
      bus.filt_rght = passes[i].fr;
      if (i == 0) begin
        fill_window();
      end else begin
        step(1'b1);
        check($sformatf("b2b%0d_seq_rise", i), 32'(bus.sequencing), 32'd1);
      end
      run_pass(i);
    end

    // Mid-pass reset: newest sample at 1001 gives start 1005, so cnt 300 reads 281.
    bus.filt_lft  = 16'h1111;
    bus.filt_rght = 16'h2222;
    step(1'b1);
    repeat (300) step(1'b0);
    check("mid_rd_ptr", 32'(bus.rd_ptr), 32'd281);
    check("mid_seq", 32'(bus.sequencing), 32'd1);
    rst = 1'b1;
    #1;
    check("arst_seq", 32'(bus.sequencing), 32'd0);
    check("arst_busy", 32'(bus.busy), 32'd0);
    check("arst_out_vld", 32'(bus.out_vld), 32'd0);
    check("arst_overrun", 32'(bus.overrun), 32'd0);
    check("arst_aud_lft", 32'(bus.aud_lft), 32'd0);
    check("arst_wr_ptr", 32'(bus.wr_ptr), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    fill_window();
    check("refill_rd_ptr", 32'(bus.rd_ptr), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
